sa3_psum_accumulator: RTL and testbench

- Downstream stage of the 3x3 systolic array. It consumes the partial sums that the bottom PE row emits, one per cycle, each tagged with its destination output pixel (c11, c12, c21, c22).
- It sums NUM_TERMS partial sums per pixel into wide accumulators, then saturates the results to OUT_W bits.
- It presents the 2x2 result tile to the next stage (activation/pooling) through a valid/ready handshake.

---
 rtl/sa_pkg.sv | 20 ++
 rtl/sa_acc_lane.sv | 53 +++++
 rtl/sa3_psum_accumulator.sv | 118 +++++++++++
 tb/tb_sa3_psum_accumulator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared pixel indices, FSM states and default widths for the psum accumulator
package sa_pkg;

  localparam logic [1:0] PIX_C11 = 2'd0;
  localparam logic [1:0] PIX_C12 = 2'd1;
  localparam logic [1:0] PIX_C21 = 2'd2;
  localparam logic [1:0] PIX_C22 = 2'd3;

  localparam int IN_W      = 8;
  localparam int ACC_W     = 16;
  localparam int OUT_W     = 8;
  localparam int NUM_TERMS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sa_acc_lane.sv
// rtl/sa_acc_lane.sv - one output pixel: wide accumulator, term counter and saturator
module sa_acc_lane #(
  parameter int IN_W      = sa_pkg::IN_W,
  parameter int ACC_W     = sa_pkg::ACC_W,
  parameter int OUT_W     = sa_pkg::OUT_W,
  parameter int NUM_TERMS = sa_pkg::NUM_TERMS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [IN_W-1:0]  data,
  output logic             full,
  output logic [OUT_W-1:0] sat_out
);

  localparam int CNT_W = $clog2(NUM_TERMS + 1);
  localparam logic [CNT_W-1:0] TERMS   = CNT_W'(NUM_TERMS);
  localparam logic [ACC_W-1:0] SAT_LIM = ACC_W'((1 << OUT_W) - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full = (cnt_q == TERMS);

  // Anything at or above the all-ones code clamps; below it passes straight through.
  assign sat_out = (acc_q >= SAT_LIM) ? {OUT_W{1'b1}} : acc_q[OUT_W-1:0];

  // Next-state: clear wins, otherwise add one term while the lane still has room.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (en && !full) begin
      acc_d = acc_q + ACC_W'(data);
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Accumulator and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sa3_psum_accumulator.sv
// rtl/sa3_psum_accumulator.sv - sums bottom-row partial sums into a saturated 2x2 tile with valid/ready output
module sa3_psum_accumulator #(
  parameter int IN_W      = sa_pkg::IN_W,
  parameter int ACC_W     = sa_pkg::ACC_W,
  parameter int OUT_W     = sa_pkg::OUT_W,
  parameter int NUM_TERMS = sa_pkg::NUM_TERMS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             psum_valid,
  input  logic [1:0]       psum_sel,
  input  logic [IN_W-1:0]  psum_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] c11,
  output logic [OUT_W-1:0] c12,
  output logic [OUT_W-1:0] c21,
  output logic [OUT_W-1:0] c22,
  output logic             busy,
  output logic             overflow_err
);

  import sa_pkg::*;

  state_t           state_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             overflow_q;
  logic [OUT_W-1:0] res_q [4];

  logic [3:0]       full;
  logic [3:0]       lane_en;
  logic [OUT_W-1:0] sat [4];
  logic             clr;
  logic             all_full;

  // A start clears the lanes unless it arrives in DONE while the tile is still unclaimed.
  assign clr      = start && ((state_q != DONE) || out_ready);
  assign all_full = &full;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    // Only accept data in ACCUM, and never on the same cycle as a restart.
    assign lane_en[i] = (state_q == ACCUM) && !start && psum_valid &&
                        (psum_sel == 2'(i)) && !full[i];

    sa_acc_lane #(
      .IN_W     (IN_W),
      .ACC_W    (ACC_W),
      .OUT_W    (OUT_W),
      .NUM_TERMS(NUM_TERMS)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .en     (lane_en[i]),
      .data   (psum_data),
      .full   (full[i]),
      .sat_out(sat[i])
    );
  end

  // Tile control FSM; the result tile is captured on the ACCUM -> DONE edge and held until handed off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      for (int k = 0; k < 4; k++) res_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            busy_q     <= 1'b1;
            overflow_q <= 1'b0;
          end
        end
        ACCUM: begin
          if (start) begin
            overflow_q <= 1'b0;
          end else begin
            if (psum_valid && full[psum_sel]) overflow_q <= 1'b1;
            if (all_full) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
              for (int k = 0; k < 4; k++) res_q[k] <= sat[k];
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (start) begin
              state_q    <= ACCUM;
              busy_q     <= 1'b1;
              overflow_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign overflow_err = overflow_q;
  assign c11          = res_q[PIX_C11];
  assign c12          = res_q[PIX_C12];
  assign c21          = res_q[PIX_C21];
  assign c22          = res_q[PIX_C22];

endmodule

// File: tb/tb_sa3_psum_accumulator.sv
// tb/tb_sa3_psum_accumulator.sv - scoreboard bench for the psum accumulator
module tb_sa3_psum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       psum_valid = 1'b0;
  logic [1:0] psum_sel = 2'd0;
  logic [7:0] psum_data = 8'd0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] c11, c12, c21, c22;
  logic       busy;
  logic       overflow_err;

  sa3_psum_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .psum_valid  (psum_valid),
    .psum_sel    (psum_sel),
    .psum_data   (psum_data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .c11         (c11),
    .c12         (c12),
    .c21         (c21),
    .c22         (c22),
    .busy        (busy),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] e11, e12, e21, e22;
    logic       ovf;
    int         at_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   last_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input int data);
    psum_valid = 1'b1;
    psum_sel   = 2'(sel);
    psum_data  = 8'(data);
    tick();
    psum_valid = 1'b0;
    last_cyc   = cyc;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_uniform(input int data);
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < 4; s++) send(s, data);
  endtask

  task automatic push(input int a, input int b, input int c, input int d, input logic ovf);
    exp_t e;
    e.e11 = 8'(a); e.e12 = 8'(b); e.e21 = 8'(c); e.e22 = 8'(d);
    e.ovf = ovf;
    e.at_cyc = last_cyc + 1;
    q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      chk("drain_timeout", 0, 1);
      q.delete();
    end
    tick();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("valid_seen", out_valid, 1);
  endtask

  // Monitor: each new result tile is popped from the scoreboard and compared.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && !prev) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("tile_c11", c11, e.e11);
          chk("tile_c12", c12, e.e12);
          chk("tile_c21", c21, e.e21);
          chk("tile_c22", c22, e.e22);
          chk("tile_ovf", overflow_err, e.ovf);
          chk("tile_latency", cyc, e.at_cyc);
        end
      end
      prev = rst_n ? out_valid : 1'b0;
    end
  end

  int t2_sel [16] = '{0, 1, -1, 2, 0, 3, -1, -1, 1, 2, 3, 0, 1, -1, 2, 3};
  int t2_dat [16] = '{200, 1, 0, 2, 200, 3, 0, 0, 2, 1, 1, 200, 3, 0, 3, 2};
  int t3_dat [12] = '{10, 100, 0, 254, 20, 100, 0, 0, 30, 100, 255, 0};

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_c11", c11, 0);
    chk("rst_c22", c22, 0);
    rst_n = 1'b1;
    tick();

    // Basic tile, in-order, all 10s
    out_ready = 1'b1;
    pulse_start();
    chk("busy_accum", busy, 1);
    send_uniform(10);
    push(30, 30, 30, 30, 1'b0);
    wait_drain();
    chk("idle_after_handoff", busy, 0);

    // Saturation with shuffled order and gaps
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      if (t2_sel[i] < 0) tick();
      else send(t2_sel[i], t2_dat[i]);
    end
    push(255, 6, 6, 6, 1'b0);
    wait_drain();

    // Backpressure; also 254 / exact 255 boundaries
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 12; i++) send(i % 4, t3_dat[i]);
    push(60, 255, 255, 254, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      psum_valid = 1'b1; psum_sel = 2'd0; psum_data = 8'd99;
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_c11", c11, 60);
      chk("bp_c22", c22, 254);
      chk("bp_ovf", overflow_err, 0);
    end
    psum_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_queue_empty", q.size(), 0);

    // Excess term on c12
    pulse_start();
    for (int i = 0; i < 3; i++) send(1, 5);
    send(1, 7);
    chk("excess_ovf_sticky", overflow_err, 1);
    for (int s = 0; s < 4; s += 2)
      for (int r = 0; r < 3; r++) send(s, 1);
    for (int r = 0; r < 3; r++) send(3, 1);
    push(3, 15, 3, 3, 1'b1);
    wait_drain();
    chk("excess_ovf_held", overflow_err, 1);

    // Restart mid-tile; the start also clears the overflow flag
    pulse_start();
    chk("start_clears_ovf", overflow_err, 0);
    for (int i = 0; i < 6; i++) send(i % 4, 50);
    pulse_start();
    send_uniform(1);
    push(3, 3, 3, 3, 1'b0);
    wait_drain();

    // Reset mid-tile discards everything
    pulse_start();
    for (int i = 0; i < 6; i++) send(i % 4, 7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_c11", c11, 0);
    chk("midrst_c21", c21, 0);
    repeat (15) tick();
    chk("midrst_no_valid", out_valid, 0);

    // Back-to-back: start together with out_ready in DONE
    out_ready = 1'b0;
    pulse_start();
    send_uniform(2);
    push(6, 6, 6, 6, 1'b0);
    wait_valid();
    out_ready = 1'b1;
    pulse_start();
    chk("b2b_valid_drop", out_valid, 0);
    chk("b2b_busy", busy, 1);
    send_uniform(4);
    push(12, 12, 12, 12, 1'b0);
    wait_drain();

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
